// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: groups every handshake and bus signal of the instruction/data
// memory-port arbiter into one bundle. These are the requester side (fetch I,
// data D) and the memory side (request/ready port plus the port mux select).
//
// Modports:
//   master - used by the arbiter. It reads the requests and the memory
//            response, and drives acks, read data, the mux select and the
//            memory request/address/data.
//   slave  - used by the surrounding environment (requesters plus memory).
//            Its directions are the mirror image of master.
//
// Signal summary (DATA_W = address/data width):
//   i_req, i_addr             fetch request (level) and address
//   i_rdata, i_ack, i_err     fetch read data, completion pulse, abort flag
//   d_req, d_we, d_addr,      data request (level), write enable, address,
//   d_wdata                   write data
//   d_rdata, d_ack, d_err     data read data, completion pulse, abort flag
//   mux_sel                   port mux select (0 = fetch, 1 = data)
//   mem_req, mem_we,          memory request, write enable, latched address,
//   mem_addr, mem_wdata       latched write data
//   mem_rdata, mem_ready      memory read data and completion
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    logic              mux_sel;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        output mux_sel, mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  mux_sel, mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares the single memory port of the MIPS datapath between the
// instruction-fetch requester (I) and the data requester (D). A request seen
// in IDLE is granted by latching its address, write data and write enable
// into the mem_* registers. The same edge raises mem_req and steers the port
// mux. The access stays open until mem_ready. The owner then gets a
// one-cycle ack and, for reads, the captured data. A watchdog aborts accesses
// whose mem_ready never arrives. Such an abort returns ack together with err
// and zero data. Every output is a register.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - synchronous active-high reset
//   bus    - mem_port_arbiter_if.master (requesters plus memory port)
//
// Parameters:
//   DATA_W   - address/data width
//   MAX_WAIT - cycles with mem_ready low before abort (0 disables the watchdog)
//   CNT_W    - watchdog counter width, must be able to hold MAX_WAIT
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, a tie between I and D goes to the
//                        requester that was not granted last. The last-grant
//                        flag resets to I, so D wins the first tie. When not
//                        defined, D always wins a tie.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_I = 2'b01,
        ST_BUSY_D = 2'b10
    } state_t;

    // The abort fires on the MAX_WAIT-th consecutive ready-low busy cycle.
    // That is the cycle in which the counter already holds MAX_WAIT-1.
    localparam bit               WD_EN    = (MAX_WAIT > 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = WD_EN ? CNT_W'(MAX_WAIT - 1)
                                                  : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_r,     state_s;
    logic                mux_sel_r,   mux_sel_s;
    logic                mem_req_r,   mem_req_s;
    logic                mem_we_r,    mem_we_s;
    logic [DATA_W-1:0]   mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0]   i_rdata_r,   i_rdata_s;
    logic [DATA_W-1:0]   d_rdata_r,   d_rdata_s;
    logic                i_ack_r,     i_ack_s;
    logic                i_err_r,     i_err_s;
    logic                d_ack_r,     d_ack_s;
    logic                d_err_r,     d_err_s;
    logic [CNT_W-1:0]    wd_cnt_r,    wd_cnt_s;

    logic                i_eff_s;
    logic                d_eff_s;
    logic                tie_d_s;
    logic                grant_d_s;
    logic                grant_i_s;
    logic                wd_hit_s;

    // A requester is ignored in its own ack cycle. Its level request is still
    // high there, and granting it again would issue a duplicate access.
    assign i_eff_s = bus.i_req & ~i_ack_r;
    assign d_eff_s = bus.d_req & ~d_ack_r;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_r;

    assign tie_d_s = ~last_d_r;

    // Remember which requester won the most recent grant, for tie-breaking.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (grant_d_s || grant_i_s)) begin
            last_d_r <= grant_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    assign tie_d_s = 1'b1;
`endif

    assign grant_d_s = d_eff_s & (~i_eff_s | tie_d_s);
    assign grant_i_s = i_eff_s & ~grant_d_s;
    assign wd_hit_s  = WD_EN && (wd_cnt_r == WD_LIMIT);

    // State and output registers. Every output of the block comes from here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mux_sel_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DATA_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            i_ack_r     <= 1'b0;
            i_err_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            d_err_r     <= 1'b0;
            wd_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            mux_sel_r   <= mux_sel_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            i_rdata_r   <= i_rdata_s;
            d_rdata_r   <= d_rdata_s;
            i_ack_r     <= i_ack_s;
            i_err_r     <= i_err_s;
            d_ack_r     <= d_ack_s;
            d_err_r     <= d_err_s;
            wd_cnt_r    <= wd_cnt_s;
        end
    end

    // Next-state and next-output logic: arbitration in IDLE, then completion
    // or watchdog abort while busy.
    always_comb begin
        state_s     = state_r;
        mux_sel_s   = mux_sel_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        i_rdata_s   = i_rdata_r;
        d_rdata_s   = d_rdata_r;
        i_ack_s     = 1'b0;
        i_err_s     = 1'b0;
        d_ack_s     = 1'b0;
        d_err_s     = 1'b0;
        wd_cnt_s    = wd_cnt_r;

        case (state_r)
            ST_IDLE: begin
                wd_cnt_s = {CNT_W{1'b0}};
                if (grant_d_s) begin
                    state_s     = ST_BUSY_D;
                    mux_sel_s   = 1'b1;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.d_we;
                    mem_addr_s  = bus.d_addr;
                    mem_wdata_s = bus.d_wdata;
                end else if (grant_i_s) begin
                    // Fetches are always reads. mem_wdata keeps its old
                    // value because memory ignores it while mem_we is low.
                    state_s     = ST_BUSY_I;
                    mux_sel_s   = 1'b0;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.i_addr;
                end else begin
                    // Nothing to do. mux_sel keeps pointing at the last owner.
                    state_s = ST_IDLE;
                end
            end

            ST_BUSY_I, ST_BUSY_D: begin
                // mem_ready is checked first. A completion in the same cycle
                // that the watchdog expires is a normal completion.
                if (bus.mem_ready) begin
                    if (state_r == ST_BUSY_I) begin
                        i_rdata_s = bus.mem_rdata;
                        i_ack_s   = 1'b1;
                    end else begin
                        if (!mem_we_r) begin
                            d_rdata_s = bus.mem_rdata;
                        end else begin
                            d_rdata_s = d_rdata_r;
                        end
                        d_ack_s = 1'b1;
                    end
                    mem_req_s = 1'b0;
                    wd_cnt_s  = {CNT_W{1'b0}};
                    state_s   = ST_IDLE;
                end else if (wd_hit_s) begin
                    if (state_r == ST_BUSY_I) begin
                        i_rdata_s = {DATA_W{1'b0}};
                        i_ack_s   = 1'b1;
                        i_err_s   = 1'b1;
                    end else begin
                        d_rdata_s = {DATA_W{1'b0}};
                        d_ack_s   = 1'b1;
                        d_err_s   = 1'b1;
                    end
                    mem_req_s = 1'b0;
                    wd_cnt_s  = {CNT_W{1'b0}};
                    state_s   = ST_IDLE;
                end else begin
                    wd_cnt_s = WD_EN ? (wd_cnt_r + CNT_ONE) : wd_cnt_r;
                end
            end

            default: begin
                // Unreachable encoding: drop any access and return to IDLE.
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                wd_cnt_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    assign bus.mux_sel   = mux_sel_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.i_ack     = i_ack_r;
    assign bus.i_err     = i_err_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_err     = d_err_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between instruction fetch (I) and data access (D) requesters in the MIPS datapath.
- Sequences each access with a request/ready handshake toward memory.
- Drives the select line of the 32-bit address/data port mux.
- Returns read data and one-cycle acknowledge/error pulses to the owning requester.
- A watchdog aborts memory accesses that never complete.

Parameters:
- DATA_W, 32, width of data and address buses.
- MAX_WAIT, 16, cycles with mem_ready low before abort; 0 disables the watchdog.
- CNT_W, 5, watchdog counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request, level; held until i_ack.
- i_addr  in  DATA_W  fetch address.
- i_rdata  out  DATA_W  fetch read data, valid with i_ack.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  qualifies i_ack: access aborted by watchdog.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1=write, 0=read.
- d_addr  in  DATA_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data, valid with d_ack.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  qualifies d_ack: aborted.
- mux_sel  out  1  port mux select: 0=I owns port, 1=D owns port.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1.
- mem_ready  in  1  memory completion, sampled only while mem_req=1.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. All outputs registered.
- Reset values: state IDLE; all other outputs 0, including rdata registers; watchdog counter 0.
- IDLE arbitration:
  - Effective request is x_req & ~x_ack; a requester is ignored in its own ack cycle.
  - D has fixed priority over I.
  - On grant: latch addr, wdata and we into the mem_* registers (I always reads, mem_we=0), set mux_sel, load state BUSY_x, set mem_req=1 at the same edge.
- BUSY_x:
  - mem_req and mux_sel held, watchdog counts each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata into x_rdata (reads only; writes leave x_rdata unchanged), pulse x_ack, clear mem_req, counter to 0, go to IDLE.
- Latency: request seen in IDLE at cycle N, mem_req=1 in N+1. With mem_ready=1 in N+1, x_ack=1 and x_rdata valid in N+2. Minimum 2 cycles request-to-ack; back-to-back grants every 2 cycles.
- Watchdog (MAX_WAIT>0): counter reaching MAX_WAIT while mem_ready=0 triggers an abort:
  - mem_req cleared.
  - x_ack=1 with x_err=1, x_rdata forced 0.
  - Next state IDLE.
  - mem_ready arriving in the same cycle as the limit wins: normal completion, no error.
- x_err is only meaningful with x_ack; it is 0 whenever x_ack=0.
- mux_sel holds its last value in IDLE.
- mem_addr, mem_wdata and mem_we are stable for the whole BUSY period.
- Requests arriving during BUSY wait; there is no preemption.
- Reset mid-access: state IDLE, mem_req 0, no ack issued; the outstanding access is dropped.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both effective requests are high in IDLE, the requester not granted last wins. The last-grant flag resets to I, so D wins the first tie.
- Not defined: fixed D priority.
- Single requests behave identically either way.

Test Plan:
- Single fetch: i_req=1, i_addr=0x00400000, mem_ready=1 one cycle after mem_req, mem_rdata=0x8C080004 -> mem_addr=0x00400000, mux_sel=0, i_ack pulse 2 cycles after request, i_rdata=0x8C080004, i_err=0.
- Data write: d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF, ready after 3 wait cycles -> mem_we=1 and mux_sel=1 held 4 cycles, d_ack one pulse, d_rdata unchanged.
- Simultaneous i_req and d_req for two accesses each -> fixed priority: D granted first, then I, then D. With ARB_ROUND_ROBIN_EN: D, I, D, I.
- Watchdog: MAX_WAIT=16, d_req read, mem_ready held 0 -> after 16 BUSY cycles d_ack=1, d_err=1, d_rdata=0, mem_req=0, state IDLE. Repeat with ready on the 16th cycle -> d_err=0.
- Reset mid-access: assert reset while in BUSY_I -> next cycle mem_req=0, i_ack=0, mux_sel=0. A subsequent fetch completes normally.
- Ack-cycle exclusion: requester keeps i_req high through its ack cycle -> exactly one memory access per request, no duplicate grant.
